// File: rtl/k2_core_gen2.sv
// K2 gen-2 accumulator core: fetch/execute FSM over an external synchronous ROM,
// with carry/zero flags, conditional jumps, halt, run/stall and an R0 update strobe.
module k2_core_gen2 #(
  parameter int DW  = 8,
  parameter int IW  = 4,
  parameter int PCW = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_i,
  output logic [PCW-1:0]  imem_addr_o,
  input  logic [IW+6:0]   imem_data_i,
  output logic [PCW-1:0]  pc_o,
  output logic [DW-1:0]   r0_o,
  output logic            r0_valid_o,
  output logic            carry_o,
  output logic            zero_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state_q;
  logic [PCW-1:0]  pc_q;
  logic [DW-1:0]   a_q, b_q, r0_q;
  logic            carry_q, zero_q, r0_valid_q, halted_q;

  logic            op_j, op_c, op_z, op_sreg, op_sub;
  logic [1:0]      op_d;
  logic [IW-1:0]   op_imm;
  logic [DW-1:0]   imm_dw, b_opnd, res_d, src_d;
  logic [PCW-1:0]  imm_pc, pc_d;
  logic [DW:0]     sum_d;
  logic            taken_d, is_halt, flags_upd;

  assign {op_j, op_c, op_z, op_d, op_sreg, op_sub, op_imm} = imem_data_i;

  // Immediate is zero-extended or truncated to fit the data path and the pc.
  if (IW >= DW) begin : g_imm_dw_trunc
    assign imm_dw = op_imm[DW-1:0];
  end else begin : g_imm_dw_ext
    assign imm_dw = {{(DW-IW){1'b0}}, op_imm};
  end

  if (IW >= PCW) begin : g_imm_pc_trunc
    assign imm_pc = op_imm[PCW-1:0];
  end else begin : g_imm_pc_ext
    assign imm_pc = {{(PCW-IW){1'b0}}, op_imm};
  end

  assign b_opnd    = op_sub ? ~b_q : b_q;
  assign sum_d     = {1'b0, a_q} + {1'b0, b_opnd} + (DW+1)'(op_sub);
  assign res_d     = sum_d[DW-1:0];
  assign src_d     = op_sreg ? imm_dw : res_d;
  // Jump decision uses the flags as they were before this instruction.
  assign taken_d   = op_j | (op_c & carry_q) | (op_z & zero_q);
  assign is_halt   = op_j & op_c & op_z;
  assign flags_upd = ~op_sreg & ~op_d[1];
  assign pc_d      = taken_d ? imm_pc : pc_q + PCW'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r0_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      r0_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      r0_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run_i) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_halt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            case (op_d)
              2'b00: a_q <= src_d;
              2'b01: b_q <= src_d;
              2'b10: begin
                r0_q       <= a_q;
                r0_valid_q <= 1'b1;
              end
              default: ;
            endcase
            if (flags_upd) begin
              carry_q <= sum_d[DW];
              zero_q  <= (res_d == '0);
            end
            pc_q    <= pc_d;
            state_q <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign r0_o        = r0_q;
  assign r0_valid_o  = r0_valid_q;
  assign carry_o     = carry_q;
  assign zero_o      = zero_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_k2_core_gen2.sv
// Bench for k2_core_gen2: directed programs plus random programs, each instruction
// checked against an instruction-level reference model of the K2 gen-2 ISA.
module tb_k2_core_gen2;
  localparam int DW  = 8;
  localparam int IW  = 4;
  localparam int PCW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic [PCW-1:0]  imem_addr, pc;
  logic [IW+6:0]   imem_data = '0;
  logic [DW-1:0]   r0;
  logic            r0_valid, carry, zero, halted;

  logic [IW+6:0]   rom [16];

  int n_vec = 0;
  int n_err = 0;

  // Reference architectural state
  int m_pc, m_a, m_b, m_r0, m_c, m_z, m_h, m_v;

  k2_core_gen2 #(.DW(DW), .IW(IW), .PCW(PCW)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .pc_o(pc), .r0_o(r0), .r0_valid_o(r0_valid),
    .carry_o(carry), .zero_o(zero), .halted_o(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  function automatic logic [IW+6:0] mk(int j, int c, int z, int d, int s, int sub, int imm);
    return {1'(j), 1'(c), 1'(z), 2'(d), 1'(s), 1'(sub), 4'(imm)};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_r0 = 0; m_c = 0; m_z = 0; m_h = 0; m_v = 0;
  endtask

  task automatic model_exec(input logic [IW+6:0] w);
    int j, c, z, d, s, sub, imm, res, cy, src, taken;
    m_v = 0;
    if (m_h != 0) return;
    j = int'(w[10]); c = int'(w[9]); z = int'(w[8]); d = int'(w[7:6]);
    s = int'(w[5]); sub = int'(w[4]); imm = int'(w[3:0]);
    if (j == 1 && c == 1 && z == 1) begin
      m_h = 1;
      return;
    end
    if (sub == 1) begin
      res = (m_a - m_b + 256) % 256;
      cy  = (m_a >= m_b) ? 1 : 0;
    end else begin
      res = (m_a + m_b) % 256;
      cy  = (m_a + m_b > 255) ? 1 : 0;
    end
    taken = (j == 1 || (c == 1 && m_c == 1) || (z == 1 && m_z == 1)) ? 1 : 0;
    src = (s == 1) ? imm % 256 : res;
    case (d)
      0: m_a = src;
      1: m_b = src;
      2: begin m_r0 = m_a; m_v = 1; end
      default: ;
    endcase
    if (s == 0 && d < 2) begin
      m_c = cy;
      m_z = (res == 0) ? 1 : 0;
    end
    m_pc = (taken == 1) ? imm % 16 : (m_pc + 1) % 16;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".r0"}, 32'(r0), 32'(m_r0));
    chk({tag, ".r0_valid"}, 32'(r0_valid), 32'(m_v));
    chk({tag, ".carry"}, 32'(carry), 32'(m_c));
    chk({tag, ".zero"}, 32'(zero), 32'(m_z));
    chk({tag, ".halted"}, 32'(halted), 32'(m_h));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  // One instruction: optional stall cycles in FETCH, the FETCH edge, then the EXEC edge.
  task automatic step(input int stall, input string tag);
    logic [IW+6:0] w;
    for (int k = 0; k < stall; k++) begin
      run = 1'b0;
      @(posedge clk); #1;
      m_v = 0;
      check_all({tag, ".stall"});
    end
    run = 1'b1;
    @(posedge clk); #1;
    m_v = 0;
    check_all({tag, ".fetch"});
    w = rom[m_pc[3:0]];
    run = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    model_exec(w);
    check_all({tag, ".exec"});
    $display("instr tag=%s pc=%0d r0=%0h c=%0d z=%0d h=%0d", tag, pc, r0, carry, zero, halted);
  endtask

  task automatic fill_noop();
    for (int i = 0; i < 16; i++) rom[i] = mk(0, 0, 0, 3, 0, 0, 0);
  endtask

  initial begin
    int steps;
    logic [IW+6:0] w;
    fill_noop();

    // Test 1: asynchronous reset in the middle of EXEC
    rom[0] = mk(0, 0, 0, 0, 1, 0, 5);
    rom[1] = mk(0, 0, 0, 2, 0, 0, 0);
    rom[2] = mk(0, 0, 0, 1, 1, 0, 3);
    do_reset();
    step(0, "t1a");
    step(0, "t1b");
    run = 1'b1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t1_async");
    @(posedge clk); #1 reset = 1'b0;
    chk("t1_addr0", 32'(imem_addr), 32'd0);
    step(0, "t1c");
    step(0, "t1d");
    chk("t1_r0", 32'(r0), 32'd5);

    // Test 2 + 6: A=3, B=5, A=A+B, R0=A, then halt after a 5-cycle stall
    fill_noop();
    rom[0] = mk(0, 0, 0, 0, 1, 0, 3);
    rom[1] = mk(0, 0, 0, 1, 1, 0, 5);
    rom[2] = mk(0, 0, 0, 0, 0, 0, 0);
    rom[3] = mk(0, 0, 0, 2, 0, 0, 0);
    rom[4] = mk(1, 1, 1, 3, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, "t2");
    chk("t2_r0", 32'(r0), 32'd8);
    chk("t2_vld", 32'(r0_valid), 32'd1);
    step(5, "t6");
    chk("t6_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_all("t6_hold");
    end
    do_reset();
    chk("t6_unhalt", 32'(halted), 32'd0);

    // Test 3: subtract underflow, then untaken jc / jz
    fill_noop();
    rom[0] = mk(0, 0, 0, 0, 1, 0, 0);
    rom[1] = mk(0, 0, 0, 1, 1, 0, 1);
    rom[2] = mk(0, 0, 0, 0, 0, 1, 0);
    rom[3] = mk(0, 1, 0, 3, 0, 0, 7);
    rom[4] = mk(0, 0, 1, 3, 0, 0, 7);
    rom[5] = mk(0, 0, 0, 2, 0, 0, 0);
    rom[6] = mk(1, 1, 1, 3, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) step(0, "t3");
    chk("t3_r0", 32'(r0), 32'hFF);
    chk("t3_pc", 32'(pc), 32'd6);

    // Test 4: count A up from 0xF until the add carries out
    fill_noop();
    rom[0] = mk(0, 0, 0, 0, 1, 0, 15);
    rom[1] = mk(0, 0, 0, 1, 1, 0, 1);
    rom[2] = mk(0, 0, 0, 0, 0, 0, 0);
    rom[3] = mk(0, 1, 0, 3, 0, 0, 5);
    rom[4] = mk(1, 0, 0, 3, 0, 0, 2);
    rom[5] = mk(0, 0, 0, 2, 0, 0, 0);
    rom[6] = mk(1, 1, 1, 3, 0, 0, 0);
    do_reset();
    steps = 0;
    while (m_h == 0 && steps < 1000) begin
      step(0, "t4");
      steps++;
    end
    chk("t4_bound", 32'(m_h), 32'd1);
    chk("t4_r0", 32'(r0), 32'd0);
    chk("t4_carry", 32'(carry), 32'd1);
    chk("t4_zero", 32'(zero), 32'd1);

    // Test 5: sixteen no-ops, pc wraps back to 0
    fill_noop();
    do_reset();
    for (int i = 0; i < 17; i++) step(0, "t5");
    chk("t5_pc", 32'(pc), 32'd1);

    // Random programs with random stalls and occasional halts
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 16; i++) begin
        w = 11'($urandom_range(0, 2047));
        if (w[10] && w[9] && w[8] && $urandom_range(0, 7) != 0) w[10] = 1'b0;
        rom[i] = w;
      end
      do_reset();
      for (int i = 0; i < 30; i++) step($urandom_range(0, 2), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
